pool_window_feeder: RTL and testbench
=====================================

POOL_WINDOW_FEEDER -- requirements
Module: pool_window_feeder

Interface
REQ-001 Parameters: data_width, default 8, bits per pixel; W, default 32, frame width in pixels; H, default 32, frame height in pixels; window fixed at 2x2, stride 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that begins a frame.
REQ-005 in_data  input  data_width  pixel, raster order (row-major, column 0 first).
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  feeder accepts in_data this cycle.
REQ-008 win_data  output  4 x data_width  window: [0]=(r,c), [1]=(r,c+1), [2]=(r+1,c), [3]=(r+1,c+1); matches pooling in1..in4.
REQ-009 win_valid  output  1  win_data is valid.
REQ-010 win_ready  input  1  consumer takes win_data this cycle.
REQ-011 busy  output  1  high while not in IDLE.
REQ-012 frame_done  output  1  one-cycle pulse when the last window of a frame is taken.

Function
REQ-013 Pixel accepted when in_valid and in_ready are both high; window transferred when win_valid and win_ready are both high.
REQ-014 FSM states: IDLE, EVEN_ROW, ODD_ROW, DONE.
REQ-015 IDLE->EVEN_ROW on start; EVEN_ROW->ODD_ROW after pixel W-1 is accepted; ODD_ROW->EVEN_ROW after pixel W-1 is accepted, if the row is not H-1; ODD_ROW->DONE on the last window transfer; DONE->IDLE on the next cycle.
REQ-016 Column and row counters reset to 0 on start and wrap the column at W-1.
REQ-017 EVEN_ROW: each accepted pixel is written to the line buffer (W entries) at the column index; no window is produced.
REQ-018 ODD_ROW, even column: the accepted pixel is held in a register.
REQ-019 ODD_ROW, odd column c: window {buf[c-1], buf[c], held, in_data} is registered; win_valid rises on the next cycle (latency 1).
REQ-020 win_data and win_valid hold stable until transferred.
REQ-021 in_ready = (state is EVEN_ROW or ODD_ROW) and (!win_valid or win_ready); in_ready is low in IDLE and DONE.
REQ-022 A window transfer and a pixel acceptance in the same cycle are both honoured, giving full throughput of one pixel per cycle.
REQ-023 start outside IDLE is ignored.
REQ-024 frame_done asserts in the cycle the FSM enters DONE; busy is low in IDLE only.
REQ-025 W and H shall be even and at least 2; elaboration shall fail otherwise.
REQ-026 Windows per frame = (W/2)*(H/2), emitted in row-pair order, then in column order.

Reset
REQ-027 On nrst low: state IDLE, counters 0, win_valid 0, win_data 0, held register 0, frame_done 0, busy 0, in_ready 0; line buffer contents are don't-care.
REQ-028 Reset mid-frame discards the partial frame; the next frame requires a new start.

Configuration
REQ-029 Macro POOL_FEEDER_WINCNT_EN defined: an extra output win_count (16 bits) counts transferred windows, clears on start and reset, and holds its final value after DONE.
REQ-030 Macro POOL_FEEDER_WINCNT_EN undefined: no win_count port and no counter logic; all other behaviour is identical.

Verification
REQ-031 W=4, H=4, pixels 0..15 streamed, win_ready=1 -> windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}; frame_done pulses once, after the 4th window.
REQ-032 Same stream, win_ready held low for 5 cycles after the first window -> win_data stays {0,1,4,5}, in_ready=0 throughout the stall, no pixel lost, all 4 windows correct.
REQ-033 in_valid toggled 1/0 every cycle, W=4, H=4 -> same 4 windows as REQ-031; each window is valid 1 cycle after its 4th pixel is accepted.
REQ-034 start pulsed again after 6 pixels -> ignored; the frame completes with correct windows.
REQ-035 nrst asserted after 10 pixels, then a new start and pixels 100..115 -> only windows from the new frame, first window {100,101,104,105}.
REQ-036 POOL_FEEDER_WINCNT_EN defined, W=8, H=4 -> win_count=8 after frame_done; win_count=0 after the next start.

Source files
------------

// File: rtl/pool_window_feeder_if.sv
// Handshake bundle between the pixel source, the 2x2 window feeder and the pooling consumer.
interface pool_window_feeder_if #(
   parameter int data_width = 8
);
   logic [data_width-1:0]      in_data;
   logic                       in_valid;
   logic                       in_ready;
   logic [3:0][data_width-1:0] win_data;
   logic                       win_valid;
   logic                       win_ready;

   modport slave (
      input  in_data, in_valid, win_ready,
      output in_ready, win_data, win_valid
   );

   modport master (
      output in_data, in_valid, win_ready,
      input  in_ready, win_data, win_valid
   );
endinterface

// File: rtl/pool_window_feeder.sv
// Converts a raster pixel stream into 2x2 stride-2 windows using one line buffer.
// Optional window counter output enabled by defining POOL_FEEDER_WINCNT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start, no pixels accepted
// EVEN_ROW | upper row of a row pair, pixels stored in the line buffer
// ODD_ROW  | lower row, windows assembled; drain_q waits for last window
// DONE     | one cycle, frame_done asserted
module pool_window_feeder #(
   parameter int data_width = 8,
   parameter int W          = 32,
   parameter int H          = 32
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 start,
   pool_window_feeder_if.slave  bus,
`ifdef POOL_FEEDER_WINCNT_EN
   output logic [15:0]          win_count,
`endif
   output logic                 busy,
   output logic                 frame_done
);

   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);

   generate
      if ((W % 2) != 0 || W < 2 || (H % 2) != 0 || H < 2) begin : g_bad_dims
         $error("pool_window_feeder: W and H must be even and at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, DONE} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              col_q, col_d;
   logic [RW-1:0]              row_q, row_d;
   logic                       drain_q, drain_d;
   logic [data_width-1:0]      held_q, held_d;
   logic [3:0][data_width-1:0] win_q, win_d;
   logic                       wv_q, wv_d;
   logic [data_width-1:0]      line_q [W];

   logic          in_ready_c;
   logic          accept;
   logic          xfer;
   logic          last_col;
   logic          last_row;
   logic [CW-1:0] col_even;

   // drain_q blocks further pixels once the final pixel of the frame is in
   assign in_ready_c = (state_q == EVEN_ROW || state_q == ODD_ROW) && !drain_q
                       && (!wv_q || bus.win_ready);
   assign accept     = bus.in_valid && in_ready_c;
   assign xfer       = wv_q && bus.win_ready;
   assign last_col   = (col_q == CW'(W - 1));
   assign last_row   = (row_q == RW'(H - 1));
   assign col_even   = col_q & ~CW'(1);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         drain_q <= 1'b0;
         held_q  <= '0;
         win_q   <= '0;
         wv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         drain_q <= drain_d;
         held_q  <= held_d;
         win_q   <= win_d;
         wv_q    <= wv_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == EVEN_ROW && accept) begin
         line_q[col_q] <= bus.in_data;
      end
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      drain_d = drain_q;
      held_d  = held_q;
      win_d   = win_q;
      wv_d    = wv_q;

      if (xfer) begin
         wv_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = EVEN_ROW;
               col_d   = '0;
               row_d   = '0;
               drain_d = 1'b0;
            end
         end
         EVEN_ROW: begin
            if (accept) begin
               col_d = last_col ? '0 : col_q + CW'(1);
               if (last_col) begin
                  row_d   = row_q + RW'(1);
                  state_d = ODD_ROW;
               end
            end
         end
         ODD_ROW: begin
            if (accept) begin
               if (!col_q[0]) begin
                  held_d = bus.in_data;
               end else begin
                  win_d[0] = line_q[col_even];
                  win_d[1] = line_q[col_q];
                  win_d[2] = held_q;
                  win_d[3] = bus.in_data;
                  wv_d     = 1'b1;
               end
               col_d = last_col ? '0 : col_q + CW'(1);
               if (last_col) begin
                  if (last_row) begin
                     drain_d = 1'b1;
                  end else begin
                     row_d   = row_q + RW'(1);
                     state_d = EVEN_ROW;
                  end
               end
            end
            if (drain_q && xfer) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            drain_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef POOL_FEEDER_WINCNT_EN
   logic [15:0] wcnt_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wcnt_q <= '0;
      end else if (state_q == IDLE && start) begin
         wcnt_q <= '0;
      end else if (xfer) begin
         wcnt_q <= wcnt_q + 16'd1;
      end
   end

   assign win_count = wcnt_q;
`endif

   assign bus.in_ready  = in_ready_c;
   assign bus.win_data  = win_q;
   assign bus.win_valid = wv_q;
   assign busy          = (state_q != IDLE);
   assign frame_done    = (state_q == DONE);

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder: 4x4 frames on one instance, an 8x4 frame on a second.
module tb_pool_window_feeder;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic busy_a, frame_done_a, busy_b, frame_done_b;
`ifdef POOL_FEEDER_WINCNT_EN
   logic [15:0] win_count_a, win_count_b;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pool_window_feeder_if #(.data_width(8)) ifa ();
   pool_window_feeder_if #(.data_width(8)) ifb ();

   pool_window_feeder #(.data_width(8), .W(4), .H(4)) dut_a (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start_a),
      .bus        (ifa),
`ifdef POOL_FEEDER_WINCNT_EN
      .win_count  (win_count_a),
`endif
      .busy       (busy_a),
      .frame_done (frame_done_a)
   );

   pool_window_feeder #(.data_width(8), .W(8), .H(4)) dut_b (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start_b),
      .bus        (ifb),
`ifdef POOL_FEEDER_WINCNT_EN
      .win_count  (win_count_b),
`endif
      .busy       (busy_b),
      .frame_done (frame_done_b)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_win(input int base, input int k, input int w);
      int r, c, p;
      r = (k / (w / 2)) * 2;
      c = (k % (w / 2)) * 2;
      p = base + r * w + c;
      return {8'(p + w + 1), 8'(p + w), 8'(p + 1), 8'(p)};
   endfunction

   // Monitor on the falling edge: records handshakes that the next rising edge performs
   logic [31:0] wins[$];
   int fd_cnt = 0;
   int fd_at = -1;
   int pc = 0;
   bit lat_en = 1'b0;
   bit lat_pend = 1'b0;
   int nb_win = 0;
   logic [31:0] first_b = '0;

   always @(negedge clk) begin
      if (lat_pend) begin
         check_eq("win_latency", ifa.win_valid, 1);
         lat_pend = 1'b0;
      end
      if (start_a && !busy_a) pc = 0;
      if (ifa.in_valid && ifa.in_ready) begin
         if (lat_en && ((pc / 4) % 2 == 1) && (pc % 2 == 1)) lat_pend = 1'b1;
         pc++;
      end
      if (ifa.win_valid && ifa.win_ready) wins.push_back(ifa.win_data);
      if (frame_done_a) begin
         fd_cnt++;
         fd_at = wins.size();
      end
      if (ifb.win_valid && ifb.win_ready) begin
         nb_win++;
         if (nb_win == 1) first_b = ifb.win_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   task automatic drive(input int base, input int n, input bit toggle);
      for (int i = 0; i < n; i++) begin
         int g;
         bit hs;
         g  = 0;
         hs = 1'b0;
         ifa.in_data  = 8'(base + i);
         ifa.in_valid = 1'b1;
         while (!hs && g < 50) begin
            @(negedge clk);
            hs = ifa.in_valid && ifa.in_ready;
            tick();
            g++;
         end
         if (!hs) check_eq("accept_timeout", 0, 1);
         if (toggle) begin
            ifa.in_valid = 1'b0;
            tick();
         end
      end
      ifa.in_valid = 1'b0;
   endtask

   task automatic stall();
      int g;
      g = 0;
      while (!ifa.win_valid && g < 60) begin
         tick();
         g++;
      end
      if (!ifa.win_valid) check_eq("stall_timeout", 0, 1);
      for (int k = 0; k < 5; k++) begin
         check_eq("stall_data", ifa.win_data, exp_win(0, 0, 4));
         check_eq("stall_in_ready", ifa.in_ready, 0);
         tick();
      end
      ifa.win_ready = 1'b1;
   endtask

   task automatic finish_frame(input int base);
      int g;
      g = 0;
      while (busy_a && g < 100) begin
         tick();
         g++;
      end
      if (busy_a) check_eq("done_timeout", 0, 1);
      check_eq("win_total", wins.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < wins.size()) check_eq($sformatf("win%0d", k), wins[k], exp_win(base, k, 4));
      end
      check_eq("frame_done_count", fd_cnt, 1);
      check_eq("frame_done_after", fd_at, 4);
      wins.delete();
      fd_cnt = 0;
      fd_at  = -1;
   endtask

   initial begin
      ifa.in_data   = '0;
      ifa.in_valid  = 1'b0;
      ifa.win_ready = 1'b1;
      ifb.in_data   = '0;
      ifb.in_valid  = 1'b0;
      ifb.win_ready = 1'b1;

      // reset state
      tick();
      check_eq("rst_in_ready", ifa.in_ready, 0);
      check_eq("rst_win_valid", ifa.win_valid, 0);
      check_eq("rst_win_data", ifa.win_data, 0);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_frame_done", frame_done_a, 0);
      nrst = 1'b1;
      ifa.in_valid = 1'b1;
      tick();
      check_eq("idle_in_ready", ifa.in_ready, 0);
      ifa.in_valid = 1'b0;
      tick();

      // plain stream, consumer always ready
      pulse_start();
      check_eq("busy_after_start", busy_a, 1);
      drive(0, 16, 1'b0);
      finish_frame(0);

      // consumer stalls on the first window
      ifa.win_ready = 1'b0;
      pulse_start();
      fork
         drive(0, 16, 1'b0);
         stall();
      join
      finish_frame(0);

      // gapped input, window latency checked by the monitor
      lat_en = 1'b1;
      pulse_start();
      drive(0, 16, 1'b1);
      finish_frame(0);
      lat_en = 1'b0;

      // start inside a frame is ignored
      pulse_start();
      drive(0, 6, 1'b0);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check_eq("busy_restart", busy_a, 1);
      drive(6, 10, 1'b0);
      finish_frame(0);

      // reset mid-frame, then a fresh frame
      pulse_start();
      drive(0, 10, 1'b0);
      nrst = 1'b0;
      tick();
      check_eq("midrst_win_valid", ifa.win_valid, 0);
      check_eq("midrst_busy", busy_a, 0);
      check_eq("midrst_in_ready", ifa.in_ready, 0);
      tick();
      nrst = 1'b1;
      tick();
      check_eq("post_rst_idle", busy_a, 0);
      wins.delete();
      fd_cnt = 0;
      fd_at  = -1;
      pulse_start();
      drive(100, 16, 1'b0);
      finish_frame(100);

      // 8x4 frame on the second instance
      begin
         int d, g;
         bit hs;
         d = 0;
         g = 0;
         start_b = 1'b1;
         tick();
         start_b = 1'b0;
         ifb.in_data  = '0;
         ifb.in_valid = 1'b1;
         while (d < 32 && g < 200) begin
            @(negedge clk);
            hs = ifb.in_valid && ifb.in_ready;
            tick();
            if (hs) begin
               d++;
               ifb.in_data = 8'(d);
            end
            g++;
         end
         ifb.in_valid = 1'b0;
         check_eq("b_pixels", d, 32);
         g = 0;
         while (busy_b && g < 50) begin
            tick();
            g++;
         end
         check_eq("b_idle", busy_b, 0);
         check_eq("b_windows", nb_win, 8);
         check_eq("b_first_win", first_b, exp_win(0, 0, 8));
`ifdef POOL_FEEDER_WINCNT_EN
         check_eq("b_win_count", win_count_b, 8);
         start_b = 1'b1;
         tick();
         start_b = 1'b0;
         check_eq("b_win_count_clr", win_count_b, 0);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
